safety_island_cmd_arbiter: RTL and testbench
============================================

Name: safety_island_cmd_arbiter

Overview:
- Shares the single safety island command/response channel between NUM_REQ requesters (lockstep monitor, ECC scrubber, watchdog service, host mailbox).
- Round-robin arbitration, with one outstanding transaction at a time.
- Tags each command with an 8-bit id, matches the returned response by id, and times out hung transactions with an error completion.
- Sits between the requester fabric and the safety island command port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); IDXW = clog2(NUM_REQ).
- TIMEOUT_CYCLES, 1024, cycles from ISSUE entry to forced error completion (≥2).
- ERR_RESP, 2'b11, resp code returned to the requester on timeout.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command request; held with payload until req_ready.
- req_opcode  in  NUM_REQ*8  packed opcodes; requester i at [8i+7:8i].
- req_addr  in  NUM_REQ*32  packed addresses.
- req_data  in  NUM_REQ*32  packed write data.
- req_ready  out  NUM_REQ  one-hot acceptance pulse.
- req_resp_valid  out  NUM_REQ  one-hot completion pulse.
- req_resp  out  2  completion code, valid with req_resp_valid.
- si_opcode  out  8  command opcode to safety island.
- si_addr  out  32  command address.
- si_data  out  32  command data.
- si_id  out  8  transaction id = {seq[7-IDXW:0], grant_idx}.
- si_valid  out  1  command valid.
- si_ready  in  1  command accepted by safety island.
- si_resp_valid  in  1  response strobe.
- si_resp  in  2  response code.
- si_resp_id  in  8  id of the returned response.
- timeout_err  out  1  one-cycle pulse on timeout completion.
- stray_resp_err  out  1  one-cycle pulse on an unmatched response.
- err_count  out  8  saturating count of timeouts plus stray responses.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all outputs 0; state IDLE; seq = 0; rr_ptr = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - If any req_valid, the winner is the first asserted index scanning rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - req_ready[winner] = 1 combinationally in that same cycle.
  - On the clock edge: latch payload, grant_idx, si_id = {seq, winner}; rr_ptr <= winner; timer <= 0; go to ISSUE.
  - Zero-latency acceptance; si_valid rises the next cycle.
- ISSUE:
  - si_valid = 1 with latched payload, stable until si_ready.
  - si_valid & si_ready → seq <= seq+1 (wraps), go to WAIT_RESP. The timer keeps running and does not restart.
- WAIT_RESP: si_resp_valid with si_resp_id == si_id → next cycle req_resp_valid[grant_idx] = 1, req_resp = si_resp; return to IDLE.
- Timer:
  - Increments every cycle in ISSUE and WAIT_RESP.
  - At timer == TIMEOUT_CYCLES-1 with no matching response that cycle:
    - Drop si_valid, aborting ISSUE; this is the only permitted valid withdrawal.
    - Next cycle req_resp_valid[grant_idx] = 1, req_resp = ERR_RESP, timeout_err = 1.
    - Return to IDLE.
- Same-cycle matching response and timeout expiry: the response wins, with no timeout_err.
- si_resp_valid in IDLE/ISSUE, or with a mismatched id: response dropped; stray_resp_err pulses the next cycle; FSM unaffected.
- err_count saturates at 255. A simultaneous timeout and stray response increment it by 2, capped at 255.
- Back-to-back: a completion cycle returns to IDLE, so a new grant can occur the cycle after req_resp_valid. Minimum period is 4 cycles with immediate si_ready and response.
- A requester deasserting req_valid before req_ready is a protocol error. It is not checked; the arbiter only samples in IDLE.
- si_* payload outputs hold their last value outside ISSUE; si_valid is the only qualifier.
- Reset asserted mid-transaction: immediate return to reset values; no completion is delivered for the in-flight transaction.

Test Plan:
- Single request: req_valid[2], opcode 0x15, addr 0x1000, si_ready same cycle, response id 0x02 resp 0 two cycles later → req_ready[2] in cycle 0; si_valid cycle 1 with si_id 0x02; req_resp_valid[2], resp 0 one cycle after response; next si_id 0x06.
- Fairness: all four req_valid held continuously with immediate responses → grant order 0,1,2,3,0,…; no requester starved.
- Timeout: TIMEOUT_CYCLES=16, si_ready=1, no response → req_resp_valid with resp 2'b11 and timeout_err 16 cycles after ISSUE entry; err_count=1. With si_ready held 0 → si_valid drops at the same point.
- Collision: matching response exactly at timer == 15 → normal completion with si_resp; timeout_err stays 0.
- Stray response: si_resp_id 0x07 while waiting on 0x02 → stray_resp_err pulse; transaction still completes on a later 0x02. Response in IDLE → stray pulse; 256 stray events → err_count = 255.
- Reset in WAIT_RESP: assert rst → outputs 0 immediately; no req_resp_valid; next grant goes to requester 0 with si_id 0x00.

Source files
------------

// File: rtl/safety_island_cmd_arbiter.sv
// Round-robin arbiter sharing the safety island command channel between NUM_REQ requesters.
// One transaction in flight; responses are matched by id and hung transactions time out.
module safety_island_cmd_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [1:0]  ERR_RESP       = 2'b11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*8-1:0]    req_opcode,
    input  logic [NUM_REQ*32-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      req_resp_valid,
    output logic [1:0]              req_resp,
    output logic [7:0]              si_opcode,
    output logic [31:0]             si_addr,
    output logic [31:0]             si_data,
    output logic [7:0]              si_id,
    output logic                    si_valid,
    input  logic                    si_ready,
    input  logic                    si_resp_valid,
    input  logic [1:0]              si_resp,
    input  logic [7:0]              si_resp_id,
    output logic                    timeout_err,
    output logic                    stray_resp_err,
    output logic [7:0]              err_count
);

    localparam int unsigned IDXW = $clog2(NUM_REQ);
    localparam int unsigned SEQW = 8 - IDXW;
    localparam int unsigned TMRW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMRW-1:0] TMR_LAST = TMRW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IDXW-1:0]   rr_ptr;
    logic [IDXW-1:0]   grant_idx;
    logic [IDXW-1:0]   winner;
    logic [IDXW-1:0]   cand;
    logic              any_req;
    logic [SEQW-1:0]   seq;
    logic [TMRW-1:0]   timer;
    logic              grant;
    logic              match;
    logic              stray;
    logic              expire;
    logic              accept;
    logic              completing;
    logic [8:0]        err_sum;

    // Round-robin pick: first asserted request after the last winner, wrapping.
    always_comb begin
        winner  = rr_ptr;
        any_req = 1'b0;
        cand    = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = IDXW'((int'(rr_ptr) + k) % int'(NUM_REQ));
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    // Completion cycle sits in IDLE but must not grant, giving the 4-cycle minimum period.
    assign completing = |req_resp_valid;

    always_comb begin
        match  = si_resp_valid && (state_q == WAIT_RESP) && (si_resp_id == si_id);
        stray  = si_resp_valid && !match;
        expire = (state_q != IDLE) && (timer == TMR_LAST) && !match;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        accept    = 1'b0;
        si_valid  = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (any_req && !completing && !rst) begin
                    grant             = 1'b1;
                    req_ready[winner] = 1'b1;
                    state_d           = ISSUE;
                end
            end
            ISSUE: begin
                // Expiry withdraws the command before the island can take it.
                if (expire) begin
                    state_d = IDLE;
                end else begin
                    si_valid = 1'b1;
                    if (si_ready) begin
                        accept  = 1'b1;
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (match || expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_sum = 9'(err_count) + 9'(expire) + 9'(stray);
    end

    // Command latch, transaction bookkeeping and completion/error reporting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr         <= IDXW'(NUM_REQ - 1);
            grant_idx      <= '0;
            seq            <= '0;
            timer          <= '0;
            si_opcode      <= '0;
            si_addr        <= '0;
            si_data        <= '0;
            si_id          <= '0;
            req_resp_valid <= '0;
            req_resp       <= '0;
            timeout_err    <= 1'b0;
            stray_resp_err <= 1'b0;
            err_count      <= '0;
        end else begin
            req_resp_valid <= '0;
            timeout_err    <= expire;
            stray_resp_err <= stray;
            err_count      <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];

            if (grant) begin
                si_opcode <= req_opcode[8*winner +: 8];
                si_addr   <= req_addr[32*winner +: 32];
                si_data   <= req_data[32*winner +: 32];
                si_id     <= {seq, winner};
                grant_idx <= winner;
                rr_ptr    <= winner;
                timer     <= '0;
            end else if (state_q != IDLE) begin
                timer <= TMRW'(timer + 1'b1);
            end

            if (accept) begin
                seq <= SEQW'(seq + 1'b1);
            end

            if (match) begin
                req_resp_valid[grant_idx] <= 1'b1;
                req_resp                  <= si_resp;
            end else if (expire) begin
                req_resp_valid[grant_idx] <= 1'b1;
                req_resp                  <= ERR_RESP;
            end
        end
    end

endmodule

// File: tb/tb_safety_island_cmd_arbiter.sv
// Bench for safety_island_cmd_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_safety_island_cmd_arbiter;

    localparam int NR = 4;
    localparam int T  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*8-1:0]   req_opcode = '0;
    logic [NR*32-1:0]  req_addr = '0;
    logic [NR*32-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_resp_valid;
    logic [1:0]        req_resp;
    logic [7:0]        si_opcode;
    logic [31:0]       si_addr;
    logic [31:0]       si_data;
    logic [7:0]        si_id;
    logic              si_valid;
    logic              si_ready = 1'b0;
    logic              si_resp_valid = 1'b0;
    logic [1:0]        si_resp = '0;
    logic [7:0]        si_resp_id = '0;
    logic              timeout_err;
    logic              stray_resp_err;
    logic [7:0]        err_count;

    int checks = 0;
    int errors = 0;

    safety_island_cmd_arbiter #(
        .NUM_REQ(NR),
        .TIMEOUT_CYCLES(T),
        .ERR_RESP(2'b11)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_opcode(req_opcode), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .req_resp_valid(req_resp_valid), .req_resp(req_resp),
        .si_opcode(si_opcode), .si_addr(si_addr), .si_data(si_data), .si_id(si_id),
        .si_valid(si_valid), .si_ready(si_ready),
        .si_resp_valid(si_resp_valid), .si_resp(si_resp), .si_resp_id(si_resp_id),
        .timeout_err(timeout_err), .stray_resp_err(stray_resp_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: who is busy, how old the transaction is, what completes next.
    bit          m_busy = 0, m_acc = 0, m_cpl = 0, m_cpl_to = 0, m_stray = 0;
    int          m_cpl_req = 0, m_start = 0, m_cyc = 0, m_seq = 0, m_last = NR - 1, m_req = 0, m_errs = 0;
    logic [1:0]  m_cpl_resp = '0;
    logic [7:0]  m_id = '0, m_op = '0;
    logic [31:0] m_addr = '0, m_data = '0;

    always @(negedge clk) begin : model
        int w, age;
        bit any, exp_v, match, stray, expire;
        logic [NR-1:0] exp_ready, exp_rrv;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_si_valid", si_valid, 0);
            chk("rst_resp_valid", req_resp_valid, 0);
            chk("rst_si_id", si_id, 0);
            chk("rst_timeout_err", timeout_err, 0);
            chk("rst_stray_err", stray_resp_err, 0);
            chk("rst_err_count", err_count, 0);
            m_busy = 0; m_acc = 0; m_cpl = 0; m_cpl_to = 0; m_stray = 0;
            m_seq = 0; m_last = NR - 1; m_errs = 0;
        end else begin
            any = 0; w = 0;
            for (int k = 1; k <= NR; k++)
                if (!any && req_valid[(m_last + k) % NR]) begin any = 1; w = (m_last + k) % NR; end
            exp_ready = '0;
            if (!m_busy && !m_cpl && any) exp_ready[w] = 1'b1;
            age   = m_cyc - m_start;
            exp_v = m_busy && !m_acc && (age != T - 1);
            exp_rrv = '0;
            if (m_cpl) exp_rrv[m_cpl_req] = 1'b1;

            chk("req_ready", req_ready, exp_ready);
            chk("si_valid", si_valid, exp_v);
            if (exp_v) begin
                chk("si_id", si_id, m_id);
                chk("si_opcode", si_opcode, m_op);
                chk("si_addr", si_addr, m_addr);
                chk("si_data", si_data, m_data);
            end
            chk("req_resp_valid", req_resp_valid, exp_rrv);
            if (m_cpl) chk("req_resp", req_resp, m_cpl_resp);
            chk("timeout_err", timeout_err, m_cpl_to);
            chk("stray_resp_err", stray_resp_err, m_stray);
            chk("err_count", err_count, (m_errs > 255) ? 255 : m_errs);

            match  = m_busy && m_acc && si_resp_valid && (si_resp_id == m_id);
            stray  = si_resp_valid && !match;
            expire = m_busy && (age == T - 1) && !match;
            m_cpl      = match || expire;
            m_cpl_resp = match ? si_resp : 2'b11;
            m_cpl_to   = expire;
            m_cpl_req  = m_req;
            m_stray    = stray;
            m_errs     = m_errs + int'(expire) + int'(stray);
            if (match || expire) m_busy = 0;
            else if (exp_v && si_ready) begin m_acc = 1; m_seq++; end
            if (exp_ready != '0) begin
                m_busy = 1; m_acc = 0; m_start = m_cyc + 1; m_req = w; m_last = w;
                m_id   = 8'((m_seq * NR + w) % 256);
                m_op   = req_opcode[8*w +: 8];
                m_addr = req_addr[32*w +: 32];
                m_data = req_data[32*w +: 32];
            end
            m_cyc++;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next();
        rst = 1'b1; req_valid = '0; si_ready = 1'b0; si_resp_valid = 1'b0;
        next(); next();
        rst = 1'b0;
    endtask

    // Called at +1 of a cycle; returns at +2 of the grant cycle (g == 0 if none came).
    task automatic wait_grant(output logic [NR-1:0] g);
        g = '0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (|req_ready) begin g = req_ready; break; end
            next();
        end
    endtask

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stim
        logic [NR-1:0] g;
        int n;
        for (int i = 0; i < NR; i++) begin
            req_opcode[8*i +: 8]  = 8'(8'h10 + i);
            req_addr[32*i +: 32]  = 32'(32'h2000_0000 + 32'h100 * i);
            req_data[32*i +: 32]  = 32'(32'hA5A5_0000 + i);
        end
        do_reset();

        // Single request from requester 2
        req_opcode[23:16] = 8'h15; req_addr[95:64] = 32'h1000; req_data[95:64] = 32'hDEAD_BEEF;
        next(); req_valid = 4'b0100;
        #1 chk("t1_ready", req_ready, 4'b0100);
        next(); req_valid = '0; si_ready = 1'b1;
        #1 chk("t1_si_valid", si_valid, 1);
        chk("t1_si_id", si_id, 8'h02);
        chk("t1_si_opcode", si_opcode, 8'h15);
        chk("t1_si_addr", si_addr, 32'h1000);
        next(); si_ready = 1'b0;
        next(); si_resp_valid = 1'b1; si_resp_id = 8'h02; si_resp = 2'b00;
        next(); si_resp_valid = 1'b0;
        #1 chk("t1_resp_valid", req_resp_valid, 4'b0100);
        chk("t1_resp", req_resp, 2'b00);
        next(); req_valid = 4'b0100;
        #1 chk("t1b_ready", req_ready, 4'b0100);
        next(); req_valid = '0; si_ready = 1'b1;
        #1 chk("t1b_si_id", si_id, 8'h06);
        next(); si_ready = 1'b0; si_resp_valid = 1'b1; si_resp_id = 8'h06; si_resp = 2'b01;
        next(); si_resp_valid = 1'b0;
        #1 chk("t1b_resp_valid", req_resp_valid, 4'b0100);

        // Fairness with all requesters held
        do_reset();
        next(); req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            wait_grant(g);
            chk("fair_grant", g, 4'(4'b0001 << (k % 4)));
            next(); si_ready = 1'b1;
            next(); si_ready = 1'b0; si_resp_valid = 1'b1; si_resp_id = m_id; si_resp = 2'b00;
            next(); si_resp_valid = 1'b0;
        end
        req_valid = '0;

        // Timeout after acceptance
        do_reset();
        next(); req_valid = 4'b0010;
        wait_grant(g);
        chk("to_grant", g, 4'b0010);
        next(); req_valid = '0; si_ready = 1'b1; n = 1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (|req_resp_valid) break;
            next(); n++;
        end
        chk("to_latency", n, 17);
        chk("to_resp_valid", req_resp_valid, 4'b0010);
        chk("to_resp", req_resp, 2'b11);
        chk("to_err_pulse", timeout_err, 1);
        chk("to_err_count", err_count, 1);

        // Timeout while never accepted, with a stray response on the expiry cycle
        next(); si_ready = 1'b0; req_valid = 4'b0001;
        wait_grant(g);
        chk("to2_grant", g, 4'b0001);
        for (int c = 1; c <= 15; c++) begin
            next();
            if (c == 1) req_valid = '0;
        end
        #1 chk("to2_valid_held", si_valid, 1);
        next(); si_resp_valid = 1'b1; si_resp_id = 8'hAA;
        #1 chk("to2_valid_drop", si_valid, 0);
        next(); si_resp_valid = 1'b0;
        #1 chk("to2_resp_valid", req_resp_valid, 4'b0001);
        chk("to2_err_pulse", timeout_err, 1);
        chk("to2_stray_pulse", stray_resp_err, 1);
        chk("to2_err_count", err_count, 3);

        // Matching response on the expiry cycle wins
        next(); req_valid = 4'b1000;
        wait_grant(g);
        chk("col_grant", g, 4'b1000);
        next(); req_valid = '0; si_ready = 1'b1;
        #1 chk("col_si_id", si_id, 8'h07);
        next(); si_ready = 1'b0;
        for (int c = 3; c <= 16; c++) next();
        si_resp_valid = 1'b1; si_resp_id = 8'h07; si_resp = 2'b01;
        next(); si_resp_valid = 1'b0;
        #1 chk("col_resp_valid", req_resp_valid, 4'b1000);
        chk("col_resp", req_resp, 2'b01);
        chk("col_no_timeout", timeout_err, 0);

        // Stray responses and saturation
        do_reset();
        next(); req_valid = 4'b0100;
        wait_grant(g);
        next(); req_valid = '0; si_ready = 1'b1;
        next(); si_ready = 1'b0; si_resp_valid = 1'b1; si_resp_id = 8'h07; si_resp = 2'b00;
        next(); si_resp_valid = 1'b0;
        #1 chk("stray_pulse", stray_resp_err, 1);
        chk("stray_no_cpl", req_resp_valid, 0);
        next(); si_resp_valid = 1'b1; si_resp_id = 8'h02; si_resp = 2'b10;
        next(); si_resp_valid = 1'b0;
        #1 chk("stray_cpl", req_resp_valid, 4'b0100);
        chk("stray_cpl_resp", req_resp, 2'b10);
        chk("stray_count1", err_count, 1);
        for (int c = 0; c < 256; c++) begin
            next(); si_resp_valid = 1'b1; si_resp_id = 8'h55;
        end
        next(); si_resp_valid = 1'b0;
        #1 chk("sat_count", err_count, 8'hFF);

        // Reset while waiting for a response
        next(); req_valid = 4'b0010;
        wait_grant(g);
        chk("rw_grant", g, 4'b0010);
        next(); req_valid = '0; si_ready = 1'b1;
        next(); si_ready = 1'b0;
        next(); rst = 1'b1;
        #1 chk("rw_si_valid", si_valid, 0);
        chk("rw_resp_valid", req_resp_valid, 0);
        chk("rw_err_count", err_count, 0);
        next(); next(); rst = 1'b0;
        next(); next(); req_valid = 4'hF;
        #1 chk("rw_next_grant", req_ready, 4'b0001);
        next(); req_valid = '0; si_ready = 1'b1;
        #1 chk("rw_next_id", si_id, 8'h00);
        next(); si_ready = 1'b0; si_resp_valid = 1'b1; si_resp_id = 8'h00; si_resp = 2'b00;
        next(); si_resp_valid = 1'b0;
        #1 chk("rw_next_cpl", req_resp_valid, 4'b0001);
        next(); next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
